// File: rtl/adder_pkg.sv
`default_nettype none
// ==========================================================================
// adder_pkg: shared defaults and types for the adder result path. Rev 1.0
// ==========================================================================
package adder_pkg;

   localparam int DATA_W_DEF = 7;
   localparam int DEPTH_DEF  = 8;
   localparam int ACC_W_DEF  = 16;
   localparam int CNT_W_DEF  = 16;

   typedef logic [DATA_W_DEF-1:0] result_t;

endpackage : adder_pkg
`default_nettype wire

// File: rtl/result_fifo.sv
`default_nettype none
// ==========================================================================
// result_fifo: first-word-fall-through FIFO with explicit occupancy. Rev 1.0
// ==========================================================================
module result_fifo #(
   parameter int DATA_W = 7,
   parameter int DEPTH  = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [DATA_W-1:0]      wdata_i,
   output logic [DATA_W-1:0]      rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    level_q, level_d;

   assign full_o  = (level_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // Caller never pushes into a full FIFO unless it pops the head in the same cycle.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_i) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push_i && !pop_i) begin
         level_d = level_q + (PTR_W+1)'(1);
      end else if (pop_i && !push_i) begin
         level_d = level_q - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage is cleared on reset so the head reads zero while empty.
   for (genvar i = 0; i < DEPTH; i++) begin : g_mem
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            mem_q[i] <= '0;
         end else if (push_i && (wr_ptr_q == PTR_W'(i))) begin
            mem_q[i] <= wdata_i;
         end
      end
   end

endmodule : result_fifo
`default_nettype wire

// File: rtl/adder_result_collector.sv
`default_nettype none
// ==========================================================================
// adder_result_collector: buffers adder sums and keeps running stats. Rev 1.0
// ==========================================================================
module adder_result_collector
   import adder_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [DATA_W-1:0]      in_data,
   input  logic                   clr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic [ACC_W-1:0]       acc_sum,
   output logic [CNT_W-1:0]       res_count,
   output logic                   acc_ovf,
   output logic                   drop_err,
   output logic [$clog2(DEPTH):0] level
);

   logic fifo_full;
   logic fifo_empty;
   logic pop;
   logic push_ok;

   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   // A full FIFO still takes the new result when its head leaves this cycle.
   assign push_ok   = in_valid && (!fifo_full || pop);

   result_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_ok),
      .pop_i   (pop),
      .wdata_i (in_data),
      .rdata_o (out_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (level)
   );

   logic [ACC_W-1:0] acc_q, acc_d, acc_base;
   logic [ACC_W:0]   acc_ext;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
   logic             ovf_q, ovf_d, ovf_base;
   logic             drop_q, drop_d, drop_base;

   // clr zeroes the baseline first so a same-cycle push or drop still lands.
   always_comb begin
      acc_base  = clr ? '0   : acc_q;
      cnt_base  = clr ? '0   : cnt_q;
      ovf_base  = clr ? 1'b0 : ovf_q;
      drop_base = clr ? 1'b0 : drop_q;
      acc_ext   = {1'b0, acc_base} + (ACC_W+1)'(in_data);

      acc_d  = acc_base;
      cnt_d  = cnt_base;
      ovf_d  = ovf_base;
      drop_d = drop_base;

      if (push_ok) begin
         acc_d = acc_ext[ACC_W-1:0];
         ovf_d = ovf_base | acc_ext[ACC_W];
         if (cnt_base != '1) begin
            cnt_d = cnt_base + CNT_W'(1);
         end
      end else if (in_valid) begin
         drop_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q  <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         drop_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
         drop_q <= drop_d;
      end
   end

   assign acc_sum   = acc_q;
   assign res_count = cnt_q;
   assign acc_ovf   = ovf_q;
   assign drop_err  = drop_q;

endmodule : adder_result_collector
`default_nettype wire

// File: tb/tb_adder_result_collector.sv
`default_nettype none
// ==========================================================================
// tb_adder_result_collector: scoreboard bench for the result collector. Rev 1.0
// ==========================================================================
module tb_adder_result_collector;
   import adder_pkg::*;

   localparam int DEPTH = DEPTH_DEF;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid;
   result_t       in_data;
   logic          clr;
   logic          out_ready;

   logic          ov_a, ovf_a, drop_a;
   result_t       od_a;
   logic [15:0]   acc_a, cnt_a;
   logic [3:0]    lvl_a;

   logic          ov_b, ovf_b, drop_b;
   result_t       od_b;
   logic [7:0]    acc_b;
   logic [15:0]   cnt_b;
   logic [3:0]    lvl_b;

   adder_result_collector dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .clr(clr),
      .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .acc_sum(acc_a),
      .res_count(cnt_a), .acc_ovf(ovf_a), .drop_err(drop_a), .level(lvl_a)
   );

   adder_result_collector #(.ACC_W(8)) dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .clr(clr),
      .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .acc_sum(acc_b),
      .res_count(cnt_b), .acc_ovf(ovf_b), .drop_err(drop_b), .level(lvl_b)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          m_level, n_push, n_drop;
   int unsigned m_acc16, m_acc8, m_cnt;
   bit          m_ovf16, m_ovf8, m_drop;
   result_t     sb[$];
   result_t     mon_exp;
   result_t     last_pop;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_clear();
      m_level = 0; m_acc16 = 0; m_acc8 = 0; m_cnt = 0;
      m_ovf16 = 0; m_ovf8 = 0; m_drop = 0;
      sb.delete();
   endtask

   // Monitor: every handshake pops the scoreboard and compares the head.
   initial begin
      forever begin
         @(negedge clk);
         if (reset && ov_a && out_ready) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL pop_unexpected: got data %0d, scoreboard empty", od_a);
            end else begin
               mon_exp = sb.pop_front();
               chk("pop_data", 32'(od_a), 32'(mon_exp));
               chk("pop_data_acc8", 32'(od_b), 32'(mon_exp));
               last_pop = mon_exp;
            end
         end
      end
   end

   // One clock of stimulus; expected state is updated and pushed to the scoreboard.
   task automatic step(input bit v, input int d, input bit r, input bit c);
      bit do_pop, do_acc;
      in_valid = v; in_data = result_t'(d); out_ready = r; clr = c;
      @(negedge clk);
      chk("out_valid", 32'(ov_a), 32'(m_level > 0));
      do_pop = r && (m_level > 0);
      do_acc = v && ((m_level < DEPTH) || do_pop);
      if (c) begin
         m_acc16 = 0; m_acc8 = 0; m_cnt = 0; m_ovf16 = 0; m_ovf8 = 0; m_drop = 0;
      end
      if (do_acc) begin
         m_acc16 += d;
         if (m_acc16 > 65535) begin m_acc16 -= 65536; m_ovf16 = 1; end
         m_acc8 += d;
         if (m_acc8 > 255) begin m_acc8 -= 256; m_ovf8 = 1; end
         if (m_cnt < 65535) m_cnt++;
         sb.push_back(result_t'(d));
      end else if (v) begin
         m_drop = 1;
      end
      m_level += (do_acc ? 1 : 0) - (do_pop ? 1 : 0);
      if (v) n_push++;
      if (v && !do_acc) n_drop++;
      @(posedge clk);
      #1;
      chk("level", 32'(lvl_a), 32'(m_level));
      chk("level_acc8", 32'(lvl_b), 32'(m_level));
      chk("acc_sum", 32'(acc_a), m_acc16);
      chk("acc_sum_acc8", 32'(acc_b), m_acc8);
      chk("res_count", 32'(cnt_a), m_cnt);
      chk("acc_ovf", 32'(ovf_a), 32'(m_ovf16));
      chk("acc_ovf_acc8", 32'(ovf_b), 32'(m_ovf8));
      chk("drop_err", 32'(drop_a), 32'(m_drop));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_out_valid"}, 32'(ov_a), 0);
      chk({tag, "_out_data"}, 32'(od_a), 0);
      chk({tag, "_acc_sum"}, 32'(acc_a), 0);
      chk({tag, "_acc_sum_acc8"}, 32'(acc_b), 0);
      chk({tag, "_res_count"}, 32'(cnt_a), 0);
      chk({tag, "_acc_ovf"}, 32'(ovf_a), 0);
      chk({tag, "_drop_err"}, 32'(drop_a), 0);
      chk({tag, "_level"}, 32'(lvl_a), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got no end expected end");
      $fatal(1, "timeout");
   end

   initial begin
      in_valid = 0; in_data = '0; clr = 0; out_ready = 0;
      model_clear();
      n_push = 0; n_drop = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      #2 reset = 1'b1;

      // Fill three entries, then drain them in order.
      step(1, 3, 0, 0);
      step(1, 5, 0, 0);
      step(1, 12, 0, 0);
      chk("p1_level", 32'(lvl_a), 3);
      chk("p1_out_data", 32'(od_a), 3);
      chk("p1_acc_sum", 32'(acc_a), 20);
      chk("p1_res_count", 32'(cnt_a), 3);
      repeat (3) step(0, 0, 1, 0);
      chk("p1_drained", 32'(ov_a), 0);
      chk("p1_last_pop", 32'(last_pop), 12);

      // Fill to DEPTH, then one more is dropped.
      step(0, 0, 0, 1);
      for (int i = 0; i < 8; i++) step(1, 10 + i, 0, 0);
      step(1, 1, 0, 0);
      chk("p2_level", 32'(lvl_a), 8);
      chk("p2_drop_err", 32'(drop_a), 1);
      chk("p2_res_count", 32'(cnt_a), 8);
      chk("p2_acc_sum", 32'(acc_a), 108);

      // Full FIFO with a same-cycle pop accepts the push.
      step(0, 0, 0, 1);
      step(1, 9, 1, 0);
      chk("p3_level", 32'(lvl_a), 8);
      chk("p3_drop_err", 32'(drop_a), 0);
      chk("p3_res_count", 32'(cnt_a), 1);
      repeat (8) step(0, 0, 1, 0);
      chk("p3_last_pop", 32'(last_pop), 9);

      // Accumulator wrap on the 8-bit instance; clr together with a push.
      step(0, 0, 0, 1);
      step(1, 127, 1, 0);
      step(1, 127, 1, 0);
      step(1, 10, 1, 0);
      chk("p4_acc8", 32'(acc_b), 8);
      chk("p4_ovf8", 32'(ovf_b), 1);
      chk("p4_acc16", 32'(acc_a), 264);
      chk("p4_ovf16", 32'(ovf_a), 0);
      step(1, 4, 1, 1);
      chk("p4_clr_acc8", 32'(acc_b), 4);
      chk("p4_clr_cnt", 32'(cnt_b), 1);
      chk("p4_clr_ovf8", 32'(ovf_b), 0);
      repeat (4) step(0, 0, 1, 0);

      // Asynchronous reset with five entries buffered.
      for (int i = 0; i < 5; i++) step(1, 21 + i, 0, 0);
      chk("p5_level", 32'(lvl_a), 5);
      #2 reset = 1'b0;
      #1;
      chk_all_zero("async_reset");
      model_clear();
      @(posedge clk);
      #3 reset = 1'b1;
      step(1, 6, 0, 0);
      chk("p5_out_data", 32'(od_a), 6);
      chk("p5_level_after", 32'(lvl_a), 1);
      step(0, 0, 1, 0);

      // Saturated input stream with a randomly toggling consumer.
      step(0, 0, 0, 1);
      n_push = 0; n_drop = 0;
      for (int i = 0; i < 200; i++)
         step(1, int'($urandom_range(0, 127)), bit'($urandom_range(0, 1)), 0);
      chk("p6_res_count", 32'(cnt_a), 32'(n_push - n_drop));
      repeat (DEPTH + 2) step(0, 0, 1, 0);
      chk("p6_sb_empty", 32'(sb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_adder_result_collector
`default_nettype wire

// File: doc/adder_result_collector.md
# adder_result_collector

Downstream consumer of the adder DUT's `c`/`valid` output stream. Captures every valid sum into a small FIFO, offers it on a ready/valid output port, and keeps a running accumulation, a result count and sticky error flags. The adder has no backpressure, so this block never stalls its input. Overflow is reported, not prevented.

## Interface
Parameters:
- `DATA_W`, 7: width of one adder result.
- `DEPTH`, 8: FIFO entries; must be a power of two, ≥ 2.
- `ACC_W`, 16: accumulator width.
- `CNT_W`, 16: result-counter width.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `reset`  in  1: asynchronous, active-low reset (asserted when 0).
- `in_valid`  in  1: adder result valid this cycle.
- `in_data`  in  DATA_W: adder sum `c`.
- `clr`  in  1: synchronous clear of accumulator, counter and sticky flags.
- `out_valid`  out  1: FIFO head available.
- `out_ready`  in  1: consumer accepts head.
- `out_data`  out  DATA_W: FIFO head.
- `acc_sum`  out  ACC_W: wrap-around sum of all accepted results.
- `res_count`  out  CNT_W: number of accepted results; saturates at all-ones.
- `acc_ovf`  out  1: sticky; set when `acc_sum` wraps.
- `drop_err`  out  1: sticky; set when a result is dropped because the FIFO is full.
- `level`  out  $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- Push: a push is attempted when `in_valid`=1.
  - It succeeds if the FIFO is not full, or if it is full and a pop happens in the same cycle.
  - Otherwise the result is dropped and `drop_err` is set.
- Pop: occurs when `out_valid` && `out_ready`. `out_data` shows the head, first-word-fall-through.
- Simultaneous push and pop:
  - Allowed at any level.
  - `level` is unchanged.
  - When empty, a pop cannot occur.
- Accepted result effects (every accepted push, not dropped ones):
  - `acc_sum` ← `acc_sum` + zero-extended `in_data`, modulo 2^ACC_W.
  - A carry out sets `acc_ovf`.
  - `res_count` increments and saturates at 2^CNT_W−1.
- `clr`:
  - Zeroes `acc_sum`, `res_count`, `acc_ovf` and `drop_err`. FIFO contents are untouched.
  - If `clr` and an accepted push occur in the same cycle, the result is `acc_sum`=`in_data` and `res_count`=1.
  - A drop in the same cycle as `clr` leaves `drop_err`=1 (set wins).
- Pointers: `DEPTH`-modulo read and write pointers plus an explicit occupancy count. Full ⇔ `level`==DEPTH; empty ⇔ `level`==0.
- Reset values, all outputs and state: `out_valid`=0, `out_data`=0, `acc_sum`=0, `res_count`=0, `acc_ovf`=0, `drop_err`=0, `level`=0. Both pointers are 0.
- Reset mid-operation: all contents are discarded immediately (asynchronous); nothing is replayed.

## Timing
- Push at edge N → `out_valid`=1 and `out_data` valid after edge N, i.e. visible in cycle N+1.
- Pop at edge N → the next entry is presented in cycle N+1 with no bubble.
- `acc_sum`, `res_count`, flags and `level` are registered and update on the same edge as the push or pop.
- `out_data` is driven from the storage array indexed by the registered read pointer. There is no combinational path from `in_*` to `out_*`.
- `out_ready` affects only the next-state logic.
- Reset deassertion is synchronised by the instantiating top. The block itself treats `reset` purely asynchronously.

## Structure
- Package `adder_pkg` holds:
  - `DATA_W_DEF`=7, `DEPTH_DEF`=8, `ACC_W_DEF`=16;
  - typedef `result_t` (logic [DATA_W_DEF-1:0]).
  - Testbench classes (generator, driver, monitor) import the same package.
- Sub-module `result_fifo`: parameterised `DATA_W`/`DEPTH`, push/pop/full/empty/level, first-word-fall-through.
- The top holds the accumulator, counter, flag logic and drop decision.
- Bind to the adder through the existing `intf`:
  - `in_valid`=`i_intf.valid`, `in_data`=`i_intf.c`.
  - `clk` and `reset` are shared with the bench; the bench drives `reset` low to reset.

## Test plan
- Reset, then push 3, 5, 12 with `out_ready`=0:
  - `level`=3, `out_data`=3, `acc_sum`=20, `res_count`=3.
  - Then raise `out_ready` → pops 3, 5, 12 on consecutive cycles; `out_valid`=0 afterwards.
- Push 8 results, then a 9th (value 1) with `out_ready`=0:
  - `level`=8, `drop_err`=1.
  - `res_count`=8, `acc_sum` excludes the 1.
- FIFO full, then push 9 with `out_ready`=1 in the same cycle:
  - Accepted, `level` stays 8, `drop_err`=0, last popped entry is 9.
- Use `ACC_W`=8 and push 127, 127, 10:
  - `acc_sum`=8, `acc_ovf`=1 after the third push.
  - `clr` together with a push of 4 → `acc_sum`=4, `res_count`=1, `acc_ovf`=0.
- Assert `reset`=0 mid-stream with `level`=5 and no clock edge:
  - All outputs are 0 immediately.
  - After release, the first push of 6 → `out_data`=6, `level`=1.
- Random stream at 100% `in_valid` with `out_ready` toggling 50%:
  - A scoreboard queue matches `out_data` order exactly.
  - `res_count` equals pushes minus drops.
